// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FETCH = 2'd2
    } arb_state_e;

    // Returned to the fetch side when a fetch times out (addi x0,x0,0).
    localparam logic [31:0] NOP_INSN    = 32'h0000_0013;
    // Access size used for every instruction fetch.
    localparam logic [2:0]  FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/arb_timer.sv
// Wait counter for one outstanding memory transaction. expired_o is high
// while the count sits one short of TIMEOUT, so a cycle that is still
// waiting at that point is the TIMEOUT-th consecutive cycle without ack.
module arb_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [7:0] cnt_q, cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) memory arbiter with one transaction in
// flight, alternating priority and a per-transaction timeout.
// Optional build macro: MEM_ARBITER_PERF_CNT_EN adds saturating stall
// cycle counters perf_fetch_stall / perf_mem_stall.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [2:0]        d_funct3,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              stall_fetch,
    output logic              stall_mem,
    output logic              err,
    input  logic              err_clr
`ifdef MEM_ARBITER_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_stall,
    output logic [31:0]       perf_mem_stall
`endif
);

    arb_state_e        state_q, state_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [2:0]        mem_funct3_q, mem_funct3_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              d_ready_q, d_ready_d;
    logic              err_q, err_d;
    logic              last_data_q, last_data_d;

    logic              timer_clr, timer_en, timer_exp;
    logic              abort;
    logic              d_want, f_want;

    arb_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (reset),
        .clear_i  (timer_clr),
        .enable_i (timer_en),
        .expired_o(timer_exp)
    );

    // A requester whose ready is pulsing this cycle still shows req high;
    // masking it stops the same request from being granted twice.
    assign d_want = d_req & ~d_ready_q;
    assign f_want = if_req & ~if_ready_q;

    // Grant, completion and timeout decisions.
    always_comb begin
        state_d      = state_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_funct3_d = mem_funct3_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_ready_d   = 1'b0;
        d_ready_d    = 1'b0;
        last_data_d  = last_data_q;
        timer_clr    = 1'b0;
        timer_en     = 1'b0;
        abort        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (d_want || f_want) begin
                    timer_clr = 1'b1;
                    mem_en_d  = 1'b1;
                    if (f_want && (!d_want || last_data_q)) begin
                        state_d      = ST_FETCH;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = if_addr;
                        mem_wdata_d  = '0;
                        mem_funct3_d = FUNCT3_WORD;
                    end else begin
                        state_d      = ST_DATA;
                        mem_we_d     = d_we;
                        mem_addr_d   = d_addr;
                        mem_wdata_d  = d_wdata;
                        mem_funct3_d = d_funct3;
                    end
                end
            end
            ST_DATA, ST_FETCH: begin
                if (mem_ack) begin
                    state_d     = ST_IDLE;
                    mem_en_d    = 1'b0;
                    last_data_d = (state_q == ST_DATA);
                    if (state_q == ST_DATA) begin
                        d_ready_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    timer_en = 1'b1;
                    if (timer_exp) begin
                        abort       = 1'b1;
                        state_d     = ST_IDLE;
                        mem_en_d    = 1'b0;
                        last_data_d = (state_q == ST_DATA);
                        if (state_q == ST_DATA) begin
                            d_ready_d = 1'b1;
                            d_rdata_d = '0;
                        end else begin
                            if_ready_d = 1'b1;
                            if_rdata_d = NOP_INSN;
                        end
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                mem_en_d = 1'b0;
            end
        endcase

        // Sticky error: a new timeout wins over a simultaneous clear.
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (abort) begin
            err_d = 1'b1;
        end
    end

    // Arbiter state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_funct3_q <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_ready_q   <= 1'b0;
            d_ready_q    <= 1'b0;
            err_q        <= 1'b0;
            last_data_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_funct3_q <= mem_funct3_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_ready_q   <= if_ready_d;
            d_ready_q    <= d_ready_d;
            err_q        <= err_d;
            last_data_q  <= last_data_d;
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_funct3  = mem_funct3_q;
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign if_ready    = if_ready_q;
    assign d_ready     = d_ready_q;
    assign err         = err_q;
    assign stall_fetch = if_req & ~if_ready_q;
    assign stall_mem   = d_req & ~d_ready_q;

`ifdef MEM_ARBITER_PERF_CNT_EN
    logic [31:0] perf_f_q, perf_m_q;

    // Saturating stall-cycle counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_f_q <= '0;
            perf_m_q <= '0;
        end else begin
            if (stall_fetch && (perf_f_q != '1)) begin
                perf_f_q <= perf_f_q + 32'd1;
            end
            if (stall_mem && (perf_m_q != '1)) begin
                perf_m_q <= perf_m_q + 32'd1;
            end
        end
    end

    assign perf_fetch_stall = perf_f_q;
    assign perf_mem_stall   = perf_m_q;
`else
    // Stall counters are absent in this build.
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model
// checked every cycle, directed scenarios with literal expectations, then
// randomized traffic.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned TO = 16;

    logic          clk, reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          if_ready;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [2:0]    d_funct3;
    logic [31:0]   d_rdata;
    logic          d_ready;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [2:0]    mem_funct3;
    logic [31:0]   mem_rdata;
    logic          mem_ack;
    logic          stall_fetch, stall_mem, err, err_clr;
`ifdef MEM_ARBITER_PERF_CNT_EN
    logic [31:0]   perf_f, perf_m;
`endif

    mem_arbiter #(
        .ADDR_W (AW),
        .TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ready   (if_ready),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_funct3   (d_funct3),
        .d_rdata    (d_rdata),
        .d_ready    (d_ready),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_funct3 (mem_funct3),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .stall_fetch(stall_fetch),
        .stall_mem  (stall_mem),
        .err        (err),
        .err_clr    (err_clr)
`ifdef MEM_ARBITER_PERF_CNT_EN
        ,
        .perf_fetch_stall(perf_f),
        .perf_mem_stall  (perf_m)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the transaction in flight plus what the requesters see.
    bit            m_busy, m_fetch, m_we, m_last_data;
    int unsigned   m_age;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [2:0]    m_f3;
    logic [31:0]   e_if_rdata, e_d_rdata;
    bit            e_if_ready, e_d_ready, e_err;

    task automatic model_reset();
        m_busy = 0; m_fetch = 0; m_we = 0; m_last_data = 0; m_age = 0;
        m_addr = '0; m_wdata = '0; m_f3 = '0;
        e_if_rdata = '0; e_d_rdata = '0;
        e_if_ready = 0; e_d_ready = 0; e_err = 0;
    endtask

    // Advance the model across one clock edge using the inputs held before it.
    task automatic model_step();
        bit nf = 0;
        bit nd = 0;
        bit ab = 0;
        bit dw, fw;
        if (m_busy) begin
            if (mem_ack) begin
                if (m_fetch) begin
                    e_if_rdata = mem_rdata; nf = 1;
                end else begin
                    if (!m_we) e_d_rdata = mem_rdata;
                    nd = 1;
                end
                m_last_data = !m_fetch; m_busy = 0;
            end else if (m_age + 1 >= TO) begin
                ab = 1;
                if (m_fetch) begin
                    e_if_rdata = 32'h0000_0013; nf = 1;
                end else begin
                    e_d_rdata = 32'h0; nd = 1;
                end
                m_last_data = !m_fetch; m_busy = 0;
            end else begin
                m_age++;
            end
        end else begin
            dw = d_req && !e_d_ready;
            fw = if_req && !e_if_ready;
            if (dw || fw) begin
                m_busy  = 1;
                m_age   = 0;
                m_fetch = fw && (!dw || m_last_data);
                if (m_fetch) begin
                    m_addr = if_addr; m_we = 0; m_f3 = 3'b010; m_wdata = '0;
                end else begin
                    m_addr = d_addr; m_we = d_we; m_f3 = d_funct3; m_wdata = d_wdata;
                end
            end
        end
        e_err      = ab ? 1'b1 : (err_clr ? 1'b0 : e_err);
        e_if_ready = nf;
        e_d_ready  = nd;
    endtask

    task automatic compare();
        check("mem_en", mem_en, m_busy);
        if (m_busy) begin
            check("mem_addr", mem_addr, m_addr);
            check("mem_we", mem_we, m_we);
            check("mem_funct3", mem_funct3, m_f3);
            if (m_we) check("mem_wdata", mem_wdata, m_wdata);
        end
        check("if_ready", if_ready, e_if_ready);
        check("d_ready", d_ready, e_d_ready);
        check("if_rdata", if_rdata, e_if_rdata);
        check("d_rdata", d_rdata, e_d_rdata);
        check("err", err, e_err);
    endtask

    // Called at posedge+1 after inputs are set; returns at the next posedge+1.
    task automatic cycle();
        #1;
        check("stall_fetch", stall_fetch, if_req && !e_if_ready);
        check("stall_mem", stall_mem, d_req && !e_d_ready);
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic quiet_inputs();
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
        d_wdata = '0; d_funct3 = '0; mem_rdata = '0; mem_ack = 0; err_clr = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    bit f_pend, d_pend;

    task automatic drive_random();
        if (e_if_ready) f_pend = 0;
        if (e_d_ready)  d_pend = 0;
        if (f_pend && $urandom_range(0, 31) == 0) f_pend = 0;
        if (d_pend && $urandom_range(0, 31) == 0) d_pend = 0;
        if (!f_pend && $urandom_range(0, 2) == 0) begin
            f_pend  = 1;
            if_addr = $urandom;
        end
        if (!d_pend && $urandom_range(0, 2) == 0) begin
            d_pend   = 1;
            d_we     = 1'($urandom_range(0, 1));
            d_addr   = $urandom;
            d_wdata  = $urandom;
            d_funct3 = 3'($urandom_range(0, 7));
        end
        if_req    = f_pend;
        d_req     = d_pend;
        mem_ack   = ($urandom_range(0, 2) == 0);
        mem_rdata = $urandom;
        err_clr   = ($urandom_range(0, 15) == 0);
    endtask

    int unsigned n;
    logic [31:0] glog [4];
    int unsigned gcnt;
    logic        prev_en;

    initial begin
        quiet_inputs();
        do_reset();
        // Reset state.
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_err", err, 1'b0);
        check("rst_readies", {if_ready, d_ready}, 2'b00);

        // Single fetch with minimum latency.
        if_req = 1; if_addr = 32'h100;
        cycle();
        check("f1_mem_en", mem_en, 1'b1);
        check("f1_mem_we", mem_we, 1'b0);
        check("f1_addr", mem_addr, 32'h100);
        check("f1_funct3", mem_funct3, 3'b010);
        mem_ack = 1; mem_rdata = 32'h0050_0093;
        cycle();
        check("f1_ready", if_ready, 1'b1);
        check("f1_rdata", if_rdata, 32'h0050_0093);
        check("f1_en_drop", mem_en, 1'b0);
        if_req = 0; mem_ack = 0;
        cycle();
        check("f1_ready_pulse", if_ready, 1'b0);

        // Both sides requesting continuously: grants alternate starting with data.
        if_req = 1; if_addr = 32'h100;
        d_req = 1; d_we = 0; d_addr = 32'h2000; d_funct3 = 3'b010;
        mem_ack = 1; mem_rdata = 32'hCAFE_0000;
        gcnt = 0; prev_en = mem_en;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (mem_en && !prev_en && gcnt < 4) begin
                glog[gcnt] = mem_addr;
                gcnt++;
            end
            prev_en = mem_en;
        end
        check("alt_count", gcnt, 4);
        check("alt_g0", glog[0], 32'h2000);
        check("alt_g1", glog[1], 32'h100);
        check("alt_g2", glog[2], 32'h2000);
        check("alt_g3", glog[3], 32'h100);
        if_req = 0; d_req = 0;
        repeat (3) cycle();
        mem_ack = 0;
        cycle();

        // Store with three wait cycles.
        d_req = 1; d_we = 1; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_funct3 = 3'b010;
        mem_rdata = 32'h1234_5678;
        cycle();
        for (int i = 0; i < 4; i++) begin
            check("st_en", mem_en, 1'b1);
            check("st_addr", mem_addr, 32'h2004);
            check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("st_we", mem_we, 1'b1);
            if (i == 3) mem_ack = 1;
            cycle();
        end
        check("st_ready", d_ready, 1'b1);
        check("st_rdata_kept", d_rdata, 32'hCAFE_0000);
        d_req = 0; mem_ack = 0;
        cycle();
        check("st_ready_pulse", d_ready, 1'b0);

        // Fetch timeout.
        if_req = 1; if_addr = 32'h300;
        cycle();
        n = 0;
        for (int i = 0; i < 40 && mem_en; i++) begin
            n++;
            cycle();
        end
        check("to_en_cycles", n, TO);
        check("to_ready", if_ready, 1'b1);
        check("to_rdata", if_rdata, 32'h0000_0013);
        check("to_err", err, 1'b1);
        if_req = 0; err_clr = 1;
        cycle();
        check("to_err_clr", err, 1'b0);
        err_clr = 0;
        cycle();

        // Reset in the middle of a data wait.
        d_req = 1; d_we = 0; d_addr = 32'h40;
        cycle();
        cycle();
        check("rm_busy", mem_en, 1'b1);
        reset = 1'b0;
        #1;
        check("rm_en", mem_en, 1'b0);
        check("rm_addr", mem_addr, 32'h0);
        check("rm_rdata", {if_rdata, d_rdata}, 64'h0);
        check("rm_ready", {if_ready, d_ready}, 2'b00);
        model_reset();
        d_req = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("rm_no_ready", d_ready, 1'b0);
        end

`ifdef MEM_ARBITER_PERF_CNT_EN
        do_reset();
        if_req = 1; if_addr = 32'h500;
        repeat (4) cycle();
        mem_ack = 1; mem_rdata = 32'h1;
        cycle();
        check("perf_fetch", perf_f, 32'd5);
        check("perf_mem", perf_m, 32'd0);
        if_req = 0; mem_ack = 0;
        cycle();
`endif

        // Randomized traffic.
        f_pend = 0; d_pend = 0;
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width.
REQ-002 SHALL have parameter TIMEOUT, default 16: max cycles waiting for mem_ack before abort (legal range 2..255).
REQ-003 SHALL have ports: clk input 1, rising-edge clock; reset input 1, asynchronous, active-low.
REQ-004 SHALL have ports: if_req input 1, fetch request; if_addr input ADDR_W, fetch address; if_rdata output 32, fetched instruction; if_ready output 1, fetch done.
REQ-005 SHALL have ports: d_req input 1, data request; d_we input 1, store when 1; d_addr input ADDR_W; d_wdata input 32; d_funct3 input 3, access size; d_rdata output 32; d_ready output 1, data done.
REQ-006 SHALL have ports: mem_en output 1; mem_we output 1; mem_addr output ADDR_W; mem_wdata output 32; mem_funct3 output 3; mem_rdata input 32; mem_ack input 1, single-cycle completion strobe.
REQ-007 SHALL have ports: stall_fetch output 1; stall_mem output 1; err output 1, sticky timeout flag; err_clr input 1.

Function
REQ-008 SHALL implement FSM states IDLE, DATA, FETCH; one memory transaction outstanding at most.
REQ-009 In IDLE, when a request is present, SHALL register the grant and enter DATA or FETCH at the next edge; mem_en/mem_* outputs are registered and high from that cycle.
REQ-010 Priority: data wins, except when last completed grant was data and if_req is high, then fetch wins (no starvation of either side).
REQ-011 SHALL hold mem_addr, mem_we, mem_wdata, mem_funct3 stable while in DATA/FETCH; mem_we = 0 in FETCH; mem_funct3 = 3'b010 in FETCH.
REQ-012 On mem_ack in DATA/FETCH SHALL register mem_rdata into d_rdata/if_rdata, pulse d_ready/if_ready for exactly one cycle next cycle, drop mem_en, return to IDLE.
REQ-013 Minimum latency: request seen at edge k, ack during cycle k+1 -> ready high in cycle k+2; back-to-back grant may start the cycle ready pulses.
REQ-014 d_rdata/if_rdata SHALL hold last value until the next completion on that side; d_rdata unchanged on store completion.
REQ-015 Requesters hold req and operands until ready; a request dropped mid-transaction SHALL not abort it (completion discarded, ready still pulses).
REQ-016 stall_fetch = if_req & ~if_ready; stall_mem = d_req & ~d_ready (combinational).
REQ-017 Wait counter SHALL clear at grant, increment each DATA/FETCH cycle without ack; on reaching TIMEOUT SHALL drop mem_en, set err, pulse the owner's ready with rdata = 32'h0000_0013 (NOP) for fetch or 0 for data, return to IDLE.
REQ-018 mem_ack in IDLE SHALL be ignored; err_clr clears err, set wins on same cycle.

Reset
REQ-019 reset low SHALL asynchronously force IDLE, all mem_* outputs 0, if_rdata/d_rdata 0, readies 0, err 0, counters 0, last-grant = fetch.
REQ-020 reset mid-transaction SHALL abandon it with no ready pulse; release is synchronous to clk.

Configuration
REQ-021 Macro MEM_ARBITER_PERF_CNT_EN defined: SHALL add outputs perf_fetch_stall and perf_mem_stall, 32 bits each, counting cycles stall_fetch/stall_mem high, saturating at 32'hFFFF_FFFF, cleared by reset.
REQ-022 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-023 Shared package mem_arb_pkg SHALL hold the state enum, NOP constant 32'h0000_0013, and funct3 word constant 3'b010.
REQ-024 Wait/timeout counter SHALL be sub-module arb_timer (clear, enable, expired); everything else flat.

Verification
REQ-025 Single fetch, if_addr=0x100, ack one cycle after mem_en, mem_rdata=0x00500093 -> if_ready at cycle k+2, if_rdata=0x00500093, mem_we=0.
REQ-026 Simultaneous if_req and d_req (load 0x2000) continuously -> grants alternate D,F,D,F; neither waits more than one transaction.
REQ-027 Store d_addr=0x2004, d_wdata=0xDEADBEEF, d_funct3=3'b010, ack after 3 wait cycles -> mem_* stable 4 cycles, d_ready one pulse, d_rdata unchanged.
REQ-028 No ack, TIMEOUT=16 -> mem_en drops after 16 cycles, err=1, if_ready with if_rdata=0x00000013; err_clr clears err.
REQ-029 reset asserted during DATA wait -> outputs 0 immediately without clock; no d_ready pulse after release.
REQ-030 With MEM_ARBITER_PERF_CNT_EN, 5-cycle fetch stall -> perf_fetch_stall=5.
